// File: rtl/vec_alu_pipe.sv
// Vector integer ALU functional unit: streams up to VLR element pairs through a
// SEGMENTS-deep pipeline. Optional signed min/max opcodes under VALU_MINMAX_EN.
module vec_alu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int MVL        = 32,
    parameter int SEGMENTS   = 4,
    parameter int ID         = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    cont_esc,
    input  logic [DATA_WIDTH:0]     op_esc,
    input  logic [MVL-1:0]          mask,
    input  logic [3:0]              opcode,
    input  logic [$clog2(MVL):0]    VLR,
    input  logic [DATA_WIDTH:0]     arg1,
    input  logic [DATA_WIDTH:0]     arg2,
    output logic [DATA_WIDTH+1:0]   out,
    output logic                    busy,
    output logic                    done
);

    localparam int VW = $clog2(MVL) + 1;
    localparam int IW = $clog2(MVL);
    localparam int SW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [VW-1:0]           r_vlr;
    logic                    r_cont_esc;
    logic [DATA_WIDTH:0]     r_op_esc;
    logic [MVL-1:0]          r_mask;
    logic [3:0]              r_opcode;
    logic [VW-1:0]           r_issue_cnt;
    logic [VW-1:0]           r_retire_cnt;
    logic                    r_busy;

    logic [DATA_WIDTH:0]     w_v1;
    logic [DATA_WIDTH-1:0]   w_a;
    logic [DATA_WIDTH-1:0]   w_b;
    logic [SW-1:0]           w_sh;
    logic [DATA_WIDTH-1:0]   w_result;
    logic [VW-1:0]           w_vlr_clip;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_tail_v;
    logic                    w_tail_m;
    logic [DATA_WIDTH-1:0]   w_tail_d;

    assign w_vlr_clip = (VLR > VW'(MVL)) ? VW'(MVL) : VLR;
    assign w_v1       = r_cont_esc ? r_op_esc : arg1;
    assign w_a        = w_v1[DATA_WIDTH-1:0];
    assign w_b        = arg2[DATA_WIDTH-1:0];
    assign w_sh       = w_a[SW-1:0];

    always_comb begin
        w_result = '0;
        case (r_opcode)
            4'd0: w_result = w_a + w_b;
            4'd1: w_result = w_b - w_a;
            4'd2: w_result = w_a & w_b;
            4'd3: w_result = w_a | w_b;
            4'd4: w_result = w_a ^ w_b;
            4'd5: w_result = w_b << w_sh;
            4'd6: w_result = w_b >> w_sh;
            4'd7: w_result = $signed(w_b) >>> w_sh;
`ifdef VALU_MINMAX_EN
            4'd8: w_result = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
            4'd9: w_result = ($signed(w_a) > $signed(w_b)) ? w_a : w_b;
`endif
            default: w_result = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (VLR == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_v1[DATA_WIDTH] && arg2[DATA_WIDTH]) begin
                    w_accept = 1'b1;
                    if (r_issue_cnt + VW'(1) == r_vlr) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            default: ;
        endcase
        // A zero-length run completes on its first cycle out of IDLE.
        if (r_state != S_IDLE) begin
            if ((r_vlr == '0) || (w_tail_v && (r_retire_cnt + VW'(1) == r_vlr))) begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_vlr        <= '0;
            r_cont_esc   <= 1'b0;
            r_op_esc     <= '0;
            r_mask       <= '0;
            r_opcode     <= '0;
            r_issue_cnt  <= '0;
            r_retire_cnt <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_vlr        <= w_vlr_clip;
                    r_cont_esc   <= cont_esc;
                    r_op_esc     <= op_esc;
                    r_mask       <= mask;
                    r_opcode     <= opcode;
                    r_issue_cnt  <= '0;
                    r_retire_cnt <= '0;
                    r_busy       <= 1'b1;
                end
            end else begin
                if (w_accept) begin
                    r_issue_cnt <= r_issue_cnt + VW'(1);
                end
                if (w_tail_v) begin
                    r_retire_cnt <= r_retire_cnt + VW'(1);
                end
                if (w_done) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SEGMENTS; gi++) begin : g_stage
            logic                  w_in_v;
            logic                  w_in_m;
            logic [DATA_WIDTH-1:0] w_in_d;
            logic                  r_v;
            logic                  r_m;
            logic [DATA_WIDTH-1:0] r_d;

            if (gi == 0) begin : g_src
                assign w_in_v = w_accept;
                assign w_in_m = r_mask[r_issue_cnt[IW-1:0]];
                assign w_in_d = w_result;
            end else begin : g_src
                assign w_in_v = g_stage[gi-1].r_v;
                assign w_in_m = g_stage[gi-1].r_m;
                assign w_in_d = g_stage[gi-1].r_d;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_m <= 1'b0;
                    r_d <= '0;
                end else if (r_busy) begin
                    r_v <= w_in_v;
                    r_m <= w_in_m;
                    r_d <= w_in_d;
                end
            end
        end
    endgenerate

    assign w_tail_v = g_stage[SEGMENTS-1].r_v;
    assign w_tail_m = g_stage[SEGMENTS-1].r_m;
    assign w_tail_d = g_stage[SEGMENTS-1].r_d;

    assign out  = w_tail_v ? {1'b1, w_tail_m, w_tail_d} : '0;
    assign busy = r_busy;
    assign done = w_done;

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Directed testbench for vec_alu_pipe with immediate-assertion checks.
module tb_vec_alu_pipe;

    localparam int DW  = 32;
    localparam int MVL = 32;
    localparam int SEG = 4;
    localparam int VW  = 6;

    logic            clk;
    logic            rst;
    logic            start;
    logic            cont_esc;
    logic [DW:0]     op_esc;
    logic [MVL-1:0]  mask;
    logic [3:0]      opcode;
    logic [VW-1:0]   VLR;
    logic [DW:0]     arg1;
    logic [DW:0]     arg2;
    logic [DW+1:0]   out;
    logic            busy;
    logic            done;

    int n_tests = 0;
    int n_fail  = 0;

    vec_alu_pipe #(
        .DATA_WIDTH(DW),
        .MVL(MVL),
        .SEGMENTS(SEG),
        .ID(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cont_esc(cont_esc),
        .op_esc(op_esc),
        .mask(mask),
        .opcode(opcode),
        .VLR(VLR),
        .arg1(arg1),
        .arg2(arg2),
        .out(out),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW:0] V(input logic [DW-1:0] x);
        return {1'b1, x};
    endfunction

    function automatic logic [DW+1:0] O(input logic m, input logic [DW-1:0] d);
        return {1'b1, m, d};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the args for the current cycle, check that cycle's outputs, advance.
    task automatic cyc(input string tag, input logic [DW:0] a1, input logic [DW:0] a2,
                       input logic [DW+1:0] eo, input logic ed);
        arg1 = a1;
        arg2 = a2;
        chk({tag, ".out"}, 64'(out), 64'(eo));
        chk({tag, ".done"}, 64'(done), 64'(ed));
        step();
    endtask

    task automatic begin_op(input logic [VW-1:0] vlr, input logic [3:0] opc,
                            input logic [MVL-1:0] msk, input logic ce, input logic [DW:0] oe);
        start    = 1'b1;
        VLR      = vlr;
        opcode   = opc;
        mask     = msk;
        cont_esc = ce;
        op_esc   = oe;
        arg1     = '0;
        arg2     = '0;
        step();
        start = 1'b0;
    endtask

    task automatic run1(input string tag, input logic [3:0] opc, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp);
        begin_op(6'd1, opc, '1, 1'b0, '0);
        cyc({tag, ".issue"}, V(a), V(b), '0, 1'b0);
        for (int i = 0; i < SEG - 1; i++) cyc({tag, ".wait"}, '0, '0, '0, 1'b0);
        cyc({tag, ".res"}, '0, '0, O(1'b1, exp), 1'b1);
        chk({tag, ".busy_end"}, 64'(busy), 64'd0);
    endtask

    logic [DW-1:0] exp_min;
    logic [DW-1:0] exp_max;

    initial begin
        rst = 1'b1; start = 1'b0; cont_esc = 1'b0; op_esc = '0; mask = '1;
        opcode = '0; VLR = '0; arg1 = '0; arg2 = '0;
        step(); step();
        chk("reset.out", 64'(out), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        rst = 1'b0;
        step();

        // Four back-to-back adds.
        begin_op(6'd4, 4'd0, '1, 1'b0, '0);
        chk("t1.busy_start", 64'(busy), 64'd1);
        cyc("t1.e0", V(1), V(10), '0, 1'b0);
        cyc("t1.e1", V(2), V(20), '0, 1'b0);
        cyc("t1.e2", V(3), V(30), '0, 1'b0);
        cyc("t1.e3", V(4), V(40), '0, 1'b0);
        cyc("t1.r0", '0, '0, O(1'b1, 32'd11), 1'b0);
        cyc("t1.r1", '0, '0, O(1'b1, 32'd22), 1'b0);
        cyc("t1.r2", '0, '0, O(1'b1, 32'd33), 1'b0);
        chk("t1.busy_last", 64'(busy), 64'd1);
        cyc("t1.r3", '0, '0, O(1'b1, 32'd44), 1'b1);
        chk("t1.busy_end", 64'(busy), 64'd0);
        chk("t1.out_end", 64'(out), 64'd0);

        // Scalar operand, sub wraps: 3 - 5.
        begin_op(6'd2, 4'd1, '1, 1'b1, V(5));
        cyc("t2.e0", '0, V(3), '0, 1'b0);
        cyc("t2.e1", '0, V(3), '0, 1'b0);
        cyc("t2.w0", '0, '0, '0, 1'b0);
        cyc("t2.w1", '0, '0, '0, 1'b0);
        cyc("t2.r0", '0, '0, O(1'b1, 32'hFFFF_FFFE), 1'b0);
        cyc("t2.r1", '0, '0, O(1'b1, 32'hFFFF_FFFE), 1'b1);
        chk("t2.busy_end", 64'(busy), 64'd0);

        // Masked run with a two-cycle bubble between elements 1 and 2.
        begin_op(6'd3, 4'd0, 32'b101, 1'b0, '0);
        cyc("t3.e0", V(1), V(1), '0, 1'b0);
        cyc("t3.e1", V(2), V(2), '0, 1'b0);
        cyc("t3.b0", '0, '0, '0, 1'b0);
        cyc("t3.b1", '0, '0, '0, 1'b0);
        cyc("t3.e2", V(3), V(3), O(1'b1, 32'd2), 1'b0);
        cyc("t3.r1", '0, '0, O(1'b0, 32'd4), 1'b0);
        cyc("t3.g0", '0, '0, '0, 1'b0);
        cyc("t3.g1", '0, '0, '0, 1'b0);
        cyc("t3.r2", '0, '0, O(1'b1, 32'd6), 1'b1);
        chk("t3.busy_end", 64'(busy), 64'd0);

        // Zero-length vector.
        begin_op(6'd0, 4'd0, '1, 1'b0, '0);
        chk("t4.vlr0_busy", 64'(busy), 64'd1);
        chk("t4.vlr0_done", 64'(done), 64'd1);
        chk("t4.vlr0_out", 64'(out), 64'd0);
        step();
        chk("t4.vlr0_busy_end", 64'(busy), 64'd0);
        chk("t4.vlr0_done_end", 64'(done), 64'd0);

        // VLR=8 with a second start while busy that must be ignored.
        begin_op(6'd8, 4'd0, '1, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            start = (i == 1);
            if (i == 1) VLR = 6'd3;
            cyc("t4.issue", V(32'(i + 1)), V(32'd100),
                (i >= SEG) ? O(1'b1, 32'(101 + i - SEG)) : '0, 1'b0);
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc("t4.drain", '0, '0, O(1'b1, 32'(105 + i)), (i == 3));
        end
        chk("t4.busy_end", 64'(busy), 64'd0);
        step();
        chk("t4.no_restart_busy", 64'(busy), 64'd0);
        chk("t4.no_restart_out", 64'(out), 64'd0);

        // Shifts and optional min/max.
`ifdef VALU_MINMAX_EN
        exp_min = 32'hFFFF_FFFF;
        exp_max = 32'd2;
`else
        exp_min = 32'd0;
        exp_max = 32'd0;
`endif
        run1("t5.sra", 4'd7, 32'd4, 32'h8000_0000, 32'hF800_0000);
        run1("t5.srl", 4'd6, 32'd4, 32'h8000_0000, 32'h0800_0000);
        run1("t5.sll", 4'd5, 32'd4, 32'd1, 32'h10);
        run1("t5.xor", 4'd4, 32'hF0F0, 32'hFF00, 32'h0FF0);
        run1("t5.min", 4'd8, 32'hFFFF_FFFF, 32'd2, exp_min);
        run1("t5.max", 4'd9, 32'hFFFF_FFFF, 32'd2, exp_max);
        run1("t5.op15", 4'd15, 32'd7, 32'd9, 32'd0);

        // Async reset mid-run after two results, then a clean run.
        begin_op(6'd6, 4'd0, '1, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            cyc("t6.issue", V(32'(i + 1)), V(32'd0),
                (i >= SEG) ? O(1'b1, 32'(i - SEG + 1)) : '0, 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("t6.rst_out", 64'(out), 64'd0);
        chk("t6.rst_busy", 64'(busy), 64'd0);
        chk("t6.rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        step();
        chk("t6.idle_out", 64'(out), 64'd0);
        begin_op(6'd6, 4'd0, '1, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            cyc("t6.rerun", V(32'(i + 10)), V(32'd1),
                (i >= SEG) ? O(1'b1, 32'(11 + i - SEG)) : '0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc("t6.redrain", '0, '0, O(1'b1, 32'(13 + i)), (i == 3));
        end
        chk("t6.busy_end", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
